// File: rtl/big_core_pkg.sv
// big_core_pkg: shared memory-map bounds and arbiter/region enums for the big_core data bus
package big_core_pkg;
  localparam logic [31:0] D_MEM_REGION_FLOOR  = 32'h0001_0000;
  localparam logic [31:0] D_MEM_REGION_ROOF   = 32'h0001_FFFF;
  localparam logic [31:0] CR_MEM_REGION_FLOOR = 32'h00FE_0000;
  localparam logic [31:0] CR_MEM_REGION_ROOF  = 32'h00FE_FFFF;
  localparam logic [31:0] VGA_MEM_REGION_FLOOR = 32'h00FF_0000;
  localparam logic [31:0] VGA_MEM_REGION_ROOF  = 32'h00FF_95FF;
  typedef enum logic {IDLE, RD_WAIT} t_mem_arb_state;
  typedef enum logic [1:0] {REG_DMEM, REG_CR, REG_VGA, REG_NONE} t_mem_region;
endpackage

// File: rtl/big_core_region_dec.sv
// big_core_region_dec: maps a byte address to its memory region (inclusive bounds)
//   addr   in  32  byte address
//   region out     decoded region, REG_NONE when unmapped
module big_core_region_dec
  import big_core_pkg::*;
(
  input  logic [31:0] addr,
  output t_mem_region region
);
  always_comb
    region = (addr >= D_MEM_REGION_FLOOR && addr <= D_MEM_REGION_ROOF) ? REG_DMEM :
             (addr >= CR_MEM_REGION_FLOOR && addr <= CR_MEM_REGION_ROOF) ? REG_CR :
             (addr >= VGA_MEM_REGION_FLOOR && addr <= VGA_MEM_REGION_ROOF) ? REG_VGA : REG_NONE;
endmodule

// File: rtl/big_core_mem_arb.sv
// big_core_mem_arb: round-robin arbiter of two masters onto the region-decoded data bus
//   Clk/Rst_N        clock, async active-low reset
//   ReqN*            request channel and read/err response of requester N (0 = core, 1 = secondary)
//   Mem*             shared target bus with one-hot region selects; MemRdData returns read data
module big_core_mem_arb
  import big_core_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Rst_N,
  input  logic        Req0Valid,
  output logic        Req0Ready,
  input  logic [31:0] Req0Addr,
  input  logic        Req0Wr,
  input  logic [3:0]  Req0ByteEn,
  input  logic [31:0] Req0WrData,
  output logic        Req0RdValid,
  output logic [31:0] Req0RdData,
  output logic        Req0Err,
  input  logic        Req1Valid,
  output logic        Req1Ready,
  input  logic [31:0] Req1Addr,
  input  logic        Req1Wr,
  input  logic [3:0]  Req1ByteEn,
  input  logic [31:0] Req1WrData,
  output logic        Req1RdValid,
  output logic [31:0] Req1RdData,
  output logic        Req1Err,
  output logic        MemDMemSel,
  output logic        MemCrSel,
  output logic        MemVgaSel,
  output logic        MemWr,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemByteEn,
  output logic [31:0] MemWrData,
  input  logic [31:0] MemRdData
);
  t_mem_arb_state state_q, state_d;
  logic [2:0]     lat_cnt_q, lat_cnt_d;
  logic           owner_q, owner_d, last_gnt_q, last_gnt_d;
  logic [1:0]     err_q, err_d, unm_rd_q, unm_rd_d;
  logic           gnt0, gnt1, gnt, g_wr, mapped, rd_go, rd_done;
  logic [31:0]    g_addr;
  t_mem_region    region;
  // Ties go to the requester not granted last; Rst_N gating keeps Ready low while reset is held.
  always_comb begin
    gnt0   = Rst_N && state_q == IDLE && Req0Valid && (!Req1Valid || last_gnt_q);
    gnt1   = Rst_N && state_q == IDLE && Req1Valid && (!Req0Valid || !last_gnt_q);
    gnt    = gnt0 || gnt1;
    g_addr = gnt1 ? Req1Addr : gnt0 ? Req0Addr : '0;
    g_wr   = gnt1 ? Req1Wr : gnt0 && Req0Wr;
  end
  big_core_region_dec u_dec (.addr(g_addr), .region(region));
  always_comb begin
    mapped      = region != REG_NONE;
    rd_go       = gnt && mapped && !g_wr;
    rd_done     = state_q == RD_WAIT && lat_cnt_q == 3'd1;
    Req0Ready   = gnt0;
    Req1Ready   = gnt1;
    MemDMemSel  = gnt && region == REG_DMEM;
    MemCrSel    = gnt && region == REG_CR;
    MemVgaSel   = gnt && region == REG_VGA;
    MemWr       = gnt && g_wr;
    MemAddr     = g_addr;
    MemByteEn   = gnt1 ? Req1ByteEn : gnt0 ? Req0ByteEn : '0;
    MemWrData   = gnt1 ? Req1WrData : gnt0 ? Req0WrData : '0;
    Req0RdValid = (rd_done && !owner_q) || unm_rd_q[0];
    Req1RdValid = (rd_done && owner_q) || unm_rd_q[1];
    Req0RdData  = (rd_done && !owner_q) ? MemRdData : '0;
    Req1RdData  = (rd_done && owner_q) ? MemRdData : '0;
    Req0Err     = err_q[0];
    Req1Err     = err_q[1];
    state_d     = rd_go ? RD_WAIT : rd_done ? IDLE : state_q;
    lat_cnt_d   = rd_go ? 3'(RD_LATENCY) : state_q == RD_WAIT ? lat_cnt_q - 3'd1 : lat_cnt_q;
    owner_d     = rd_go ? gnt1 : owner_q;
    last_gnt_d  = gnt ? gnt1 : last_gnt_q;
    err_d       = {gnt1 && !mapped, gnt0 && !mapped};
    unm_rd_d    = {gnt1 && !mapped && !g_wr, gnt0 && !mapped && !g_wr};
  end
  always_ff @(posedge Clk or negedge Rst_N)
    if (!Rst_N) begin
      state_q    <= IDLE;
      lat_cnt_q  <= '0;
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      err_q      <= '0;
      unm_rd_q   <= '0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      owner_q    <= owner_d;
      last_gnt_q <= last_gnt_d;
      err_q      <= err_d;
      unm_rd_q   <= unm_rd_d;
    end
endmodule

// File: tb/tb_big_core_mem_arb.sv
// tb_big_core_mem_arb: directed bench; u0 uses RD_LATENCY=2, u1 (shared inputs) uses RD_LATENCY=3
module tb_big_core_mem_arb;
  logic        Clk = 1'b0, Rst_N = 1'b0;
  logic        Req0Valid = 0, Req0Wr = 0, Req1Valid = 0, Req1Wr = 0;
  logic [31:0] Req0Addr = 0, Req0WrData = 0, Req1Addr = 0, Req1WrData = 0, MemRdData = 0;
  logic [3:0]  Req0ByteEn = 0, Req1ByteEn = 0;
  logic        Req0Ready, Req0RdValid, Req0Err, Req1Ready, Req1RdValid, Req1Err;
  logic [31:0] Req0RdData, Req1RdData, MemAddr, MemWrData;
  logic        MemDMemSel, MemCrSel, MemVgaSel, MemWr;
  logic [3:0]  MemByteEn;
  logic        b_Req0Ready, b_Req0RdValid, b_Req0Err, b_Req1Ready, b_Req1RdValid, b_Req1Err;
  logic [31:0] b_Req0RdData, b_Req1RdData, b_MemAddr, b_MemWrData;
  logic        b_MemDMemSel, b_MemCrSel, b_MemVgaSel, b_MemWr;
  logic [3:0]  b_MemByteEn;
  int n_run = 0, n_fail = 0;

  always #5 Clk = ~Clk;

  big_core_mem_arb #(.RD_LATENCY(2)) u0 (
    .Clk(Clk), .Rst_N(Rst_N),
    .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0Addr(Req0Addr), .Req0Wr(Req0Wr),
    .Req0ByteEn(Req0ByteEn), .Req0WrData(Req0WrData), .Req0RdValid(Req0RdValid),
    .Req0RdData(Req0RdData), .Req0Err(Req0Err),
    .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1Addr(Req1Addr), .Req1Wr(Req1Wr),
    .Req1ByteEn(Req1ByteEn), .Req1WrData(Req1WrData), .Req1RdValid(Req1RdValid),
    .Req1RdData(Req1RdData), .Req1Err(Req1Err),
    .MemDMemSel(MemDMemSel), .MemCrSel(MemCrSel), .MemVgaSel(MemVgaSel), .MemWr(MemWr),
    .MemAddr(MemAddr), .MemByteEn(MemByteEn), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  big_core_mem_arb #(.RD_LATENCY(3)) u1 (
    .Clk(Clk), .Rst_N(Rst_N),
    .Req0Valid(Req0Valid), .Req0Ready(b_Req0Ready), .Req0Addr(Req0Addr), .Req0Wr(Req0Wr),
    .Req0ByteEn(Req0ByteEn), .Req0WrData(Req0WrData), .Req0RdValid(b_Req0RdValid),
    .Req0RdData(b_Req0RdData), .Req0Err(b_Req0Err),
    .Req1Valid(Req1Valid), .Req1Ready(b_Req1Ready), .Req1Addr(Req1Addr), .Req1Wr(Req1Wr),
    .Req1ByteEn(Req1ByteEn), .Req1WrData(Req1WrData), .Req1RdValid(b_Req1RdValid),
    .Req1RdData(b_Req1RdData), .Req1Err(b_Req1Err),
    .MemDMemSel(b_MemDMemSel), .MemCrSel(b_MemCrSel), .MemVgaSel(b_MemVgaSel), .MemWr(b_MemWr),
    .MemAddr(b_MemAddr), .MemByteEn(b_MemByteEn), .MemWrData(b_MemWrData), .MemRdData(MemRdData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #1;
    chk("rst_ready0", 32'(Req0Ready), 0);
    chk("rst_ready1", 32'(Req1Ready), 0);
    chk("rst_sel", 32'({MemDMemSel, MemCrSel, MemVgaSel}), 0);
    chk("rst_memwr", 32'(MemWr), 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_rdvalid", 32'({Req0RdValid, Req1RdValid}), 0);
    chk("rst_err", 32'({Req0Err, Req1Err}), 0);
    @(negedge Clk);
    @(negedge Clk);
    Rst_N = 1'b1;
    // contention: both hold write Valid, grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Req0Valid = 1; Req0Wr = 1; Req0Addr = 32'h0001_0000; Req0ByteEn = 4'hF;
      Req1Valid = 1; Req1Wr = 1; Req1Addr = 32'h0001_0004; Req1ByteEn = 4'h3;
      #1;
      chk($sformatf("cont_ready0_%0d", i), 32'(Req0Ready), 32'(i % 2 == 0));
      chk($sformatf("cont_ready1_%0d", i), 32'(Req1Ready), 32'(i % 2 == 1));
      chk($sformatf("cont_addr_%0d", i), MemAddr, (i % 2 == 0) ? 32'h0001_0000 : 32'h0001_0004);
    end
    // single write
    @(negedge Clk);
    Req1Valid = 0;
    Req0Addr = 32'h0001_0010; Req0WrData = 32'hDEAD_BEEF; Req0ByteEn = 4'hF;
    #1;
    chk("wr_ready0", 32'(Req0Ready), 1);
    chk("wr_dmemsel", 32'(MemDMemSel), 1);
    chk("wr_memwr", 32'(MemWr), 1);
    chk("wr_addr", MemAddr, 32'h0001_0010);
    chk("wr_data", MemWrData, 32'hDEAD_BEEF);
    chk("wr_be", 32'(MemByteEn), 32'hF);
    @(negedge Clk);
    Req0Valid = 0;
    #1;
    chk("wr_no_rdvalid", 32'(Req0RdValid), 0);
    chk("wr_no_err", 32'(Req0Err), 0);
    // read with RD_LATENCY=2, Req1 held valid to observe Ready low during the wait
    @(negedge Clk);
    Req1Valid = 1; Req1Wr = 0; Req1Addr = 32'h00FE_0018; MemRdData = 32'h3FF;
    #1;
    chk("rd_ready_T", 32'(Req1Ready), 1);
    chk("rd_crsel_T", 32'(MemCrSel), 1);
    chk("rd_memwr_T", 32'(MemWr), 0);
    @(negedge Clk);
    #1;
    chk("rd_ready_T1", 32'(Req1Ready), 0);
    chk("rd_crsel_T1", 32'(MemCrSel), 0);
    chk("rd_rdvalid_T1", 32'(Req1RdValid), 0);
    @(negedge Clk);
    #1;
    chk("rd_ready_T2", 32'(Req1Ready), 0);
    chk("rd_rdvalid_T2", 32'(Req1RdValid), 1);
    chk("rd_data_T2", Req1RdData, 32'h3FF);
    chk("rd_other_data", Req0RdData, 0);
    chk("rd_other_valid", 32'(Req0RdValid), 0);
    @(negedge Clk);
    Req1Valid = 0;
    #1;
    chk("rd_rdvalid_T3", 32'(Req1RdValid), 0);
    @(negedge Clk);
    // unmapped read
    @(negedge Clk);
    Req0Valid = 1; Req0Wr = 0; Req0Addr = 32'h0080_0000;
    #1;
    chk("unm_ready", 32'(Req0Ready), 1);
    chk("unm_sel", 32'({MemDMemSel, MemCrSel, MemVgaSel}), 0);
    @(negedge Clk);
    Req0Valid = 0;
    #1;
    chk("unm_err", 32'(Req0Err), 1);
    chk("unm_rdvalid", 32'(Req0RdValid), 1);
    chk("unm_rddata", Req0RdData, 0);
    chk("unm_other_err", 32'(Req1Err), 0);
    @(negedge Clk);
    #1;
    chk("unm_err_clear", 32'(Req0Err), 0);
    chk("unm_rdvalid_clear", 32'(Req0RdValid), 0);
    // VGA boundary
    @(negedge Clk);
    Req1Valid = 1; Req1Wr = 1; Req1Addr = 32'h00FF_95FF;
    #1;
    chk("vga_last_sel", 32'(MemVgaSel), 1);
    @(negedge Clk);
    Req1Addr = 32'h00FF_9600;
    #1;
    chk("vga_past_ready", 32'(Req1Ready), 1);
    chk("vga_past_sel", 32'(MemVgaSel), 0);
    chk("vga_last_noerr", 32'(Req1Err), 0);
    @(negedge Clk);
    Req1Valid = 0;
    #1;
    chk("vga_past_err", 32'(Req1Err), 1);
    chk("vga_past_no_rdvalid", 32'(Req1RdValid), 0);
    // reset mid-read on the RD_LATENCY=3 instance
    @(negedge Clk);
    Req0Valid = 1; Req0Wr = 0; Req0Addr = 32'h0001_0020; MemRdData = 32'h55;
    #1;
    chk("mr_ready_T", 32'(b_Req0Ready), 1);
    chk("mr_dmemsel_T", 32'(b_MemDMemSel), 1);
    @(negedge Clk);
    Req0Valid = 0;
    #2 Rst_N = 1'b0;
    #1;
    chk("mr_rdvalid_rst", 32'(b_Req0RdValid), 0);
    @(negedge Clk);
    Rst_N = 1'b1;
    for (int i = 2; i < 6; i++) begin
      #1;
      chk($sformatf("mr_no_rdvalid_T%0d", i), 32'(b_Req0RdValid), 0);
      @(negedge Clk);
    end
    Req0Valid = 1;
    #1;
    chk("mr_ready_T6", 32'(b_Req0Ready), 1);
    @(negedge Clk);
    Req0Valid = 0;
    #1;
    chk("mr_rdvalid_T7", 32'(b_Req0RdValid), 0);
    @(negedge Clk);
    #1;
    chk("mr_rdvalid_T8", 32'(b_Req0RdValid), 0);
    @(negedge Clk);
    #1;
    chk("mr_rdvalid_T9", 32'(b_Req0RdValid), 1);
    chk("mr_rddata_T9", b_Req0RdData, 32'h55);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/big_core_mem_arb.md
# big_core_mem_arb

Two-requester arbiter sharing the big_core data-side memory-mapped bus between the core's memory-stage port (requester 0) and a secondary master such as a debug or loader port (requester 1). Grants requests round-robin, decodes the address into D_MEM, CR or VGA regions and drives a single target bus with per-region selects. Tracks one outstanding read and routes its data back to the requester that issued it. Sits between the core/debug masters and the D_MEM, CR and VGA memories.

## Interface
- RD_LATENCY, 1: target read latency in cycles (1..4).
- Clk  in  1  core clock.
- Rst_N  in  1  asynchronous, active-low reset.
- Req0Valid / Req1Valid  in  1  request valid.
- Req0Ready / Req1Ready  out  1  request accepted this cycle.
- Req0Addr / Req1Addr  in  32  byte address.
- Req0Wr / Req1Wr  in  1  1 = write, 0 = read.
- Req0ByteEn / Req1ByteEn  in  4  byte enables.
- Req0WrData / Req1WrData  in  32  write data.
- Req0RdValid / Req1RdValid  out  1  read-response strobe.
- Req0RdData / Req1RdData  out  32  read data, valid with RdValid.
- Req0Err / Req1Err  out  1  unmapped-access pulse.
- MemDMemSel / MemCrSel / MemVgaSel  out  1  one-hot region select, qualifies the access.
- MemWr  out  1  write enable.
- MemAddr  out  32  address.
- MemByteEn  out  4  byte enables.
- MemWrData  out  32  write data.
- MemRdData  in  32  read data from the selected region.

## Operation
- **Region decode** (inclusive bounds):
  - D_MEM: D_MEM_REGION_FLOOR..D_MEM_REGION_ROOF.
  - CR: CR_MEM_REGION_FLOOR..CR_MEM_REGION_ROOF.
  - VGA: VGA_MEM_REGION_FLOOR..VGA_MEM_REGION_ROOF.
  - Any other address is UNMAPPED.
- **States:** IDLE and RD_WAIT.
- **IDLE:**
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not granted last. LastGnt resets to 1, so requester 0 wins the first tie.
  - Grant means ReqNReady=1 and the Mem* bus is driven combinationally from that requester in the same cycle. LastGnt updates on every grant.
- **Write grant:** the access completes in the grant cycle; the state stays IDLE.
- **Read grant to a mapped region:** load LatCnt=RD_LATENCY, record Owner, go to RD_WAIT.
- **UNMAPPED grant:**
  - No Mem*Sel is asserted.
  - ReqNErr pulses in the next cycle.
  - A read also pulses ReqNRdValid with RdData=0 in the next cycle.
  - The state stays IDLE.
- **RD_WAIT:**
  - Both Ready signals are 0. Mem*Sel are 0 except in the grant cycle.
  - LatCnt decrements each cycle.
  - When LatCnt==1: assert ReqOwnerRdValid, drive ReqOwnerRdData=MemRdData, return to IDLE.
- The non-owner's RdData is 0.

## Timing
- **Reset values:** all Ready, RdValid, Err and Mem*Sel are 0; MemWr=0; data and address outputs are 0; state is IDLE; LastGnt=1.
- Requests are accepted in the same cycle (combinational grant from IDLE).
- **Read accepted at cycle T:**
  - RdValid is in cycle T+RD_LATENCY.
  - Ready is 0 for T+1..T+RD_LATENCY.
  - A new grant is possible at T+RD_LATENCY+1.
- Back-to-back writes: one per cycle, alternating between requesters under contention.
- A requester must hold Valid and its payload stable until Ready. Dropping Valid before Ready is legal and cancels the request.
- **Asynchronous reset mid-read:** the pending read is dropped, no RdValid is produced, and the state returns to IDLE immediately.
- A requester granted while its previous read response is still due cannot occur, because only one read is outstanding.

## Structure
- Add to big_core_pkg:
  - t_mem_arb_state enum {IDLE, RD_WAIT}.
  - t_mem_region enum {REG_DMEM, REG_CR, REG_VGA, REG_NONE}.
- The region bounds already live there.
- One combinational sub-module, big_core_region_dec: 32-bit address in, t_mem_region out. It is reused by the debug path.
- LatCnt is 3 bits wide. Owner and LastGnt are single flops.

## Test plan
- **Single write:** Req0 writes 0xDEADBEEF to 0x0001_0010, ByteEn=0xF → Req0Ready and MemDMemSel high with MemWr=1 in the same cycle; no RdValid.
- **Read latency:** RD_LATENCY=2; Req1 reads 0x00FE_0018 with MemRdData=0x3FF → MemCrSel pulses at T; Req1RdValid and Req1RdData=0x3FF at T+2; Req1Ready=0 at T+1..T+2.
- **Contention:** both requesters hold write Valid for 4 cycles after reset → grants go 0,1,0,1.
- **Unmapped access:** Req0 reads 0x0080_0000 → no Mem*Sel; next cycle Req0Err=1, Req0RdValid=1, Req0RdData=0.
- **VGA boundary:** access 0x00FF_95FF selects VGA; access 0x00FF_9600 gives Err.
- **Reset mid-read:** Rst_N low at T+1 of a read with RD_LATENCY=3 → no RdValid ever appears; after release, a read issued at T+6 completes normally.
